rename_reg_file: RTL and testbench

//   Architectural register file with per-register rename tags. Sits between decode/issue and the

---
 rtl/rename_reg_file_pkg.sv | 18 +
 rtl/rename_reg_file_rrf_read_port.sv | 41 ++++
 rtl/rename_reg_file.sv | 114 +++++++++++
 tb/tb_rename_reg_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_reg_file_pkg.sv
// Shared constants and types for the rename register file.
// Optional same-cycle commit forwarding is enabled by defining COMMIT_BYPASS_EN.
package rename_reg_file_pkg;

    localparam int ROB_INDEX_BIT = 4;
    localparam int REG_NUM       = 32;
    localparam int REG_IDX_BIT   = 5;
    localparam int DATA_W        = 32;

    typedef logic [REG_IDX_BIT-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]      data_t;

    // x0 is architecturally zero and must never look busy
    function automatic logic is_x0(input reg_idx_t idx);
        return (idx == '0);
    endfunction

endpackage

// File: rtl/rename_reg_file_rrf_read_port.sv
// One decode operand read port: x0 masking plus optional commit forwarding
// (compiled in when COMMIT_BYPASS_EN is defined).
module rrf_read_port #(
    parameter int ROB_IDX_W = 4
) (
    input  logic [4:0]           idx_i,
    input  logic [31:0]          raw_val_i,
    input  logic                 raw_busy_i,
    input  logic [ROB_IDX_W-1:0] raw_tag_i,
`ifdef COMMIT_BYPASS_EN
    input  logic                 commit_en_i,
    input  logic [4:0]           commit_rd_i,
    input  logic [31:0]          commit_val_i,
    input  logic [ROB_IDX_W-1:0] commit_rob_id_i,
`endif
    output logic [31:0]          val_o,
    output logic                 busy_o,
    output logic [ROB_IDX_W-1:0] tag_o
);
    import rename_reg_file_pkg::*;

    always_comb begin
        val_o  = '0;
        busy_o = 1'b0;
        tag_o  = '0;
        if (!is_x0(idx_i)) begin
            val_o  = raw_val_i;
            busy_o = raw_busy_i;
            tag_o  = raw_tag_i;
`ifdef COMMIT_BYPASS_EN
            // Only the producer the register is waiting on may forward
            if (commit_en_i && (commit_rd_i == idx_i) && raw_busy_i &&
                (raw_tag_i == commit_rob_id_i)) begin
                val_o  = commit_val_i;
                busy_o = 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags (issue renames, commit retires).
// Define COMMIT_BYPASS_EN to forward a retiring value to same-cycle operand reads.
module rename_reg_file #(
    parameter int REG_NUM   = rename_reg_file_pkg::REG_NUM,
    parameter int ROB_IDX_W = rename_reg_file_pkg::ROB_INDEX_BIT
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 issue_en,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_IDX_W-1:0] issue_rob_id,
    input  logic                 commit_en,
    input  logic [4:0]           commit_rd,
    input  logic [31:0]          commit_val,
    input  logic [ROB_IDX_W-1:0] commit_rob_id,
    input  logic [4:0]           rs1_idx,
    input  logic [4:0]           rs2_idx,
    output logic [31:0]          rs1_val,
    output logic                 rs1_busy,
    output logic [ROB_IDX_W-1:0] rs1_tag,
    output logic [31:0]          rs2_val,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs2_tag
);
    import rename_reg_file_pkg::*;

    logic [31:0]          val_q  [REG_NUM];
    logic                 busy_q [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_q  [REG_NUM];

    logic [REG_NUM-1:0] commit_sel;
    logic [REG_NUM-1:0] issue_sel;
    logic [REG_NUM-1:0] retire_sel;

    // Per-register write decode; entry 0 never selects so x0 stays at its reset value
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_decode
            if (gi == 0) begin : g_zero
                assign commit_sel[gi] = 1'b0;
                assign issue_sel[gi]  = 1'b0;
                assign retire_sel[gi] = 1'b0;
            end else begin : g_reg
                assign commit_sel[gi] = commit_en && (commit_rd == REG_IDX_BIT'(gi));
                assign issue_sel[gi]  = issue_en && (issue_rd == REG_IDX_BIT'(gi));
                assign retire_sel[gi] = commit_sel[gi] && busy_q[gi] &&
                                        (tag_q[gi] == commit_rob_id);
            end
        end
    endgenerate

    // Priority per register: flush > new rename > matching retire; value write is independent
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_sel[i]) begin
                    val_q[i] <= commit_val;
                end
                if (clear_in) begin
                    busy_q[i] <= 1'b0;
                end else if (issue_sel[i]) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= issue_rob_id;
                end else if (retire_sel[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    rrf_read_port #(
        .ROB_IDX_W(ROB_IDX_W)
    ) u_rs1_port (
        .idx_i           (rs1_idx),
        .raw_val_i       (val_q[rs1_idx]),
        .raw_busy_i      (busy_q[rs1_idx]),
        .raw_tag_i       (tag_q[rs1_idx]),
`ifdef COMMIT_BYPASS_EN
        .commit_en_i     (commit_en),
        .commit_rd_i     (commit_rd),
        .commit_val_i    (commit_val),
        .commit_rob_id_i (commit_rob_id),
`endif
        .val_o           (rs1_val),
        .busy_o          (rs1_busy),
        .tag_o           (rs1_tag)
    );

    rrf_read_port #(
        .ROB_IDX_W(ROB_IDX_W)
    ) u_rs2_port (
        .idx_i           (rs2_idx),
        .raw_val_i       (val_q[rs2_idx]),
        .raw_busy_i      (busy_q[rs2_idx]),
        .raw_tag_i       (tag_q[rs2_idx]),
`ifdef COMMIT_BYPASS_EN
        .commit_en_i     (commit_en),
        .commit_rd_i     (commit_rd),
        .commit_val_i    (commit_val),
        .commit_rob_id_i (commit_rob_id),
`endif
        .val_o           (rs2_val),
        .busy_o          (rs2_busy),
        .tag_o           (rs2_tag)
    );

endmodule

// File: tb/tb_rename_reg_file.sv
// Randomized bench for rename_reg_file with an array-based reference model of the
// architectural state; directed cases cover reset, rename/retire ordering, flush and x0.
module tb_rename_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_id;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_val;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs2_val;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    // Reference architectural state
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    rename_reg_file dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .issue_en      (issue_en),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .commit_en     (commit_en),
        .commit_rd     (commit_rd),
        .commit_val    (commit_val),
        .commit_rob_id (commit_rob_id),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rs1_val       (rs1_val),
        .rs1_busy      (rs1_busy),
        .rs1_tag       (rs1_tag),
        .rs2_val       (rs2_val),
        .rs2_busy      (rs2_busy),
        .rs2_tag       (rs2_tag)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h want=0x%08h", tag, cycle_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Apply the architectural rules for one clock edge using the currently driven inputs
    task automatic model_edge();
        if (rdy_in) begin
            if (commit_en && commit_rd != 0) begin
                m_val[commit_rd] = commit_val;
                if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id)
                    m_busy[commit_rd] = 1'b0;
            end
            if (clear_in) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (issue_en && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_rob_id;
            end
        end
    endtask

    task automatic check_reads();
        check_eq("rs1_val",  rs1_val,  m_val[rs1_idx]);
        check_eq("rs1_busy", {31'b0, rs1_busy}, {31'b0, m_busy[rs1_idx]});
        if (m_busy[rs1_idx]) check_eq("rs1_tag", {28'b0, rs1_tag}, {28'b0, m_tag[rs1_idx]});
        check_eq("rs2_val",  rs2_val,  m_val[rs2_idx]);
        check_eq("rs2_busy", {31'b0, rs2_busy}, {31'b0, m_busy[rs2_idx]});
        if (m_busy[rs2_idx]) check_eq("rs2_tag", {28'b0, rs2_tag}, {28'b0, m_tag[rs2_idx]});
    endtask

    // Inputs are set just after a negedge; check pre-edge reads, clock, advance model
    task automatic step();
        #1;
        check_reads();
        $display("cyc=%0d rdy=%0b clr=%0b iss=%0b rd=%0d id=%0d com=%0b rd=%0d id=%0d val=%08h rs1=%0d:%08h/%0b/%0d rs2=%0d:%08h/%0b/%0d",
                 cycle_no, rdy_in, clear_in, issue_en, issue_rd, issue_rob_id, commit_en,
                 commit_rd, commit_rob_id, commit_val, rs1_idx, rs1_val, rs1_busy, rs1_tag,
                 rs2_idx, rs2_val, rs2_busy, rs2_tag);
        @(posedge clk_in);
        model_edge();
        cycle_no++;
        @(negedge clk_in);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        rdy_in = 1'b1; clear_in = 1'b0;
        issue_en = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_en = 1'b0; commit_rd = '0; commit_val = '0; commit_rob_id = '0;
        rs1_idx = r1; rs2_idx = r2;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] id);
        idle(rd, 5'd0);
        issue_en = 1'b1; issue_rd = rd; issue_rob_id = id;
        step();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
        idle(rd, 5'd0);
        commit_en = 1'b1; commit_rd = rd; commit_rob_id = id; commit_val = v;
        step();
    endtask

    initial begin
        model_reset();
        idle(5'd0, 5'd0);
        rst_in = 1'b1;
        rs1_idx = 5'd7; rs2_idx = 5'd31;
        #2;
        check_eq("rst_rs1_val",  rs1_val, 32'h0);
        check_eq("rst_rs2_busy", {31'b0, rs2_busy}, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Rename then retire with matching tag
        do_issue(5'd3, 4'd7);
        idle(5'd3, 5'd0); #1;
        check_eq("t2_busy", {31'b0, rs1_busy}, 32'h1);
        check_eq("t2_tag",  {28'b0, rs1_tag}, 32'h7);
        do_commit(5'd3, 4'd7, 32'hDEADBEEF);
        idle(5'd3, 5'd0); #1;
        check_eq("t2_val_after", rs1_val, 32'hDEADBEEF);
        check_eq("t2_busy_after", {31'b0, rs1_busy}, 32'h0);
        step();

        // Older writer retires while a younger rename is pending
        do_issue(5'd4, 4'd2);
        do_issue(5'd4, 4'd5);
        do_commit(5'd4, 4'd2, 32'd11);
        idle(5'd4, 5'd0); #1;
        check_eq("t3_val",  rs1_val, 32'd11);
        check_eq("t3_busy", {31'b0, rs1_busy}, 32'h1);
        check_eq("t3_tag",  {28'b0, rs1_tag}, 32'h5);
        step();

        // Same-cycle issue and commit to one register
        idle(5'd6, 5'd0);
        issue_en = 1'b1; issue_rd = 5'd6; issue_rob_id = 4'd9;
        commit_en = 1'b1; commit_rd = 5'd6; commit_rob_id = 4'd1; commit_val = 32'd42;
        step();
        idle(5'd6, 5'd0); #1;
        check_eq("t4_val",  rs1_val, 32'd42);
        check_eq("t4_busy", {31'b0, rs1_busy}, 32'h1);
        check_eq("t4_tag",  {28'b0, rs1_tag}, 32'h9);
        step();

        // Flush drops the concurrent rename
        do_issue(5'd8, 4'd1);
        do_issue(5'd9, 4'd2);
        idle(5'd8, 5'd9);
        clear_in = 1'b1; issue_en = 1'b1; issue_rd = 5'd10; issue_rob_id = 4'd3;
        step();
        idle(5'd10, 5'd9); #1;
        check_eq("t5_x10_busy", {31'b0, rs1_busy}, 32'h0);
        check_eq("t5_x9_busy",  {31'b0, rs2_busy}, 32'h0);
        rs1_idx = 5'd8; #1;
        check_eq("t5_x8_busy",  {31'b0, rs1_busy}, 32'h0);
        check_eq("t5_x4_busy_model", {31'b0, m_busy[4]}, 32'h0);
        step();

        // x0 is immutable; rdy low freezes everything
        idle(5'd0, 5'd0);
        issue_en = 1'b1; issue_rd = 5'd0; issue_rob_id = 4'd4;
        commit_en = 1'b1; commit_rd = 5'd0; commit_rob_id = 4'd4; commit_val = 32'd123;
        step();
        idle(5'd0, 5'd0); #1;
        check_eq("t6_x0_val",  rs1_val, 32'h0);
        check_eq("t6_x0_busy", {31'b0, rs1_busy}, 32'h0);
        do_commit(5'd2, 4'd0, 32'd55);
        idle(5'd2, 5'd0);
        rdy_in = 1'b0; commit_en = 1'b1; commit_rd = 5'd2; commit_val = 32'd99;
        issue_en = 1'b1; issue_rd = 5'd2; issue_rob_id = 4'd6; clear_in = 1'b1;
        step();
        idle(5'd2, 5'd0); #1;
        check_eq("t6_x2_val",  rs1_val, 32'd55);
        check_eq("t6_x2_busy", {31'b0, rs1_busy}, 32'h0);
        step();

        // Randomized traffic concentrated on a few registers to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] crd;
            idle(5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
            rdy_in       = ($urandom_range(0, 9) != 0);
            clear_in     = ($urandom_range(0, 19) == 0);
            issue_en     = $urandom_range(0, 1) != 0;
            issue_rd     = 5'($urandom_range(0, 9));
            issue_rob_id = 4'($urandom);
            commit_en    = $urandom_range(0, 1) != 0;
            crd          = 5'($urandom_range(0, 9));
            commit_rd    = crd;
            commit_rob_id = ($urandom_range(0, 9) < 7) ? m_tag[crd] : 4'($urandom);
            commit_val   = $urandom;
            step();
        end

        // Asynchronous reset mid-run with x5 busy
        do_issue(5'd5, 4'd12);
        idle(5'd5, 5'd3);
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("t1_rst_val",  rs1_val, 32'h0);
        check_eq("t1_rst_busy", {31'b0, rs1_busy}, 32'h0);
        check_eq("t1_rst_tag",  {28'b0, rs1_tag}, 32'h0);
        check_eq("t1_rst_x3",   rs2_val, 32'h0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
